// File: rtl/data_mem_ctrl.sv
// data_mem_ctrl: MEM-stage data RAM initiator; sub-word stores are done as
// read-modify-write, misaligned accesses are reported as AdEL/AdES.
//
// Ports:
//   clk, rst                         clock, async active-high reset
//   req_i, we_i, size_i, sext_i      request, store, size (00 b/01 h/1x w),
//                                    load sign-extend
//   addr_i, wdata_i                  byte address, right-justified store data
//   stall_o                          pipeline hold (combinational)
//   done_o, rdata_o                  completion pulse, extended load data
//   adel_o, ades_o, bad_addr_o       address-error pulses, faulting address
//   ram_we_o, ram_addr_o, ram_data_o RAM write enable, word address, write data
//   ram_data_i                       RAM read data (combinational)
module data_mem_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_i,
    input  logic        we_i,
    input  logic [1:0]  size_i,
    input  logic        sext_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    output logic        stall_o,
    output logic        done_o,
    output logic [31:0] rdata_o,
    output logic        adel_o,
    output logic        ades_o,
    output logic [31:0] bad_addr_o,
    output logic        ram_we_o,
    output logic [31:0] ram_addr_o,
    output logic [31:0] ram_data_o,
    input  logic [31:0] ram_data_i
);

    typedef enum logic {IDLE, MERGE_WR} state_t;

    state_t      state, state_nx;
    logic [31:0] merge;
    logic [29:0] lat_addr;

    logic        aligned;
    logic        sub;
    logic [4:0]  shift;
    logic [31:0] mask;
    logic [31:0] shifted;
    logic [31:0] ld_ext;
    logic [31:0] merged;

    // Lane position: big-endian, so offset 0 is the most significant lane.
    always_comb begin
        aligned = 1'b1;
        case (size_i)
            2'b00:   aligned = 1'b1;
            2'b01:   aligned = ~addr_i[0];
            default: aligned = (addr_i[1:0] == 2'b00);
        endcase
        sub     = ~size_i[1];
        shift   = size_i[0] ? {~addr_i[1], 4'b0000}
                            : {~addr_i[1:0], 3'b000};
        mask    = (size_i[0] ? 32'h0000_FFFF : 32'h0000_00FF) << shift;
        shifted = ram_data_i >> shift;
        if (size_i[1])
            ld_ext = ram_data_i;
        else if (size_i[0])
            ld_ext = {{16{sext_i & shifted[15]}}, shifted[15:0]};
        else
            ld_ext = {{24{sext_i & shifted[7]}}, shifted[7:0]};
        merged  = (ram_data_i & ~mask) | ((wdata_i << shift) & mask);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nx;
    end

    always_comb begin
        state_nx   = state;
        stall_o    = 1'b0;
        ram_we_o   = 1'b0;
        ram_addr_o = 32'h0;
        ram_data_o = 32'h0;
        case (state)
            IDLE: begin
                if (req_i && aligned) begin
                    ram_addr_o = {addr_i[31:2], 2'b00};
                    if (we_i && !sub) begin
                        ram_we_o   = 1'b1;
                        ram_data_o = wdata_i;
                    end
                    if (we_i && sub) begin
                        stall_o  = 1'b1;
                        state_nx = MERGE_WR;
                    end
                end
            end
            default: begin
                ram_we_o   = 1'b1;
                ram_addr_o = {lat_addr, 2'b00};
                ram_data_o = merge;
                stall_o    = 1'b1;
                state_nx   = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            done_o     <= 1'b0;
            rdata_o    <= 32'h0;
            adel_o     <= 1'b0;
            ades_o     <= 1'b0;
            bad_addr_o <= 32'h0;
            merge      <= 32'h0;
            lat_addr   <= 30'h0;
        end else begin
            done_o <= 1'b0;
            adel_o <= 1'b0;
            ades_o <= 1'b0;
            case (state)
                IDLE: begin
                    if (req_i) begin
                        if (!aligned) begin
                            done_o     <= 1'b1;
                            adel_o     <= ~we_i;
                            ades_o     <= we_i;
                            bad_addr_o <= addr_i;
                            rdata_o    <= 32'h0;
                        end else if (!we_i) begin
                            done_o  <= 1'b1;
                            rdata_o <= ld_ext;
                        end else if (!sub) begin
                            done_o  <= 1'b1;
                            rdata_o <= 32'h0;
                        end else begin
                            merge    <= merged;
                            lat_addr <= addr_i[31:2];
                        end
                    end
                end
                default: begin
                    done_o  <= 1'b1;
                    rdata_o <= 32'h0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_data_mem_ctrl.sv
// tb_data_mem_ctrl: self-checking bench for data_mem_ctrl with a small
// behavioural RAM and an expected-result queue.
module tb_data_mem_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_i = 1'b0;
    logic        we_i = 1'b0;
    logic [1:0]  size_i = 2'b00;
    logic        sext_i = 1'b0;
    logic [31:0] addr_i = 32'h0;
    logic [31:0] wdata_i = 32'h0;
    logic        stall_o, done_o, adel_o, ades_o, ram_we_o;
    logic [31:0] rdata_o, bad_addr_o, ram_addr_o, ram_data_o, ram_data_i;

    typedef struct packed {
        logic [31:0] rdata;
        logic        adel;
        logic        ades;
        logic [31:0] bad;
    } exp_t;

    exp_t        sbq[$];
    exp_t        e;
    logic [31:0] mem[0:15];
    int          vectors = 0;
    int          errors = 0;
    int          wr_cnt = 0;

    data_mem_ctrl dut (
        .clk(clk), .rst(rst), .req_i(req_i), .we_i(we_i),
        .size_i(size_i), .sext_i(sext_i), .addr_i(addr_i),
        .wdata_i(wdata_i), .stall_o(stall_o), .done_o(done_o),
        .rdata_o(rdata_o), .adel_o(adel_o), .ades_o(ades_o),
        .bad_addr_o(bad_addr_o), .ram_we_o(ram_we_o),
        .ram_addr_o(ram_addr_o), .ram_data_o(ram_data_o),
        .ram_data_i(ram_data_i)
    );

    always #5 clk = ~clk;

    // RAM: combinational read, reads zero while writing, writes on the edge.
    assign ram_data_i = ram_we_o ? 32'h0 : mem[ram_addr_o[5:2]];
    always @(posedge clk) begin
        if (ram_we_o) begin
            mem[ram_addr_o[5:2]] <= ram_data_o;
            wr_cnt = wr_cnt + 1;
        end
    end

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic w, input logic [1:0] sz,
                         input logic sx, input logic [31:0] a,
                         input logic [31:0] wd);
        req_i = 1'b1; we_i = w; size_i = sz; sext_i = sx;
        addr_i = a; wdata_i = wd;
        #1;
    endtask

    task automatic idle;
        req_i = 1'b0; we_i = 1'b0; size_i = 2'b00; sext_i = 1'b0;
        addr_i = 32'h0; wdata_i = 32'h0;
    endtask

    task automatic push(input logic [31:0] r, input logic l,
                        input logic s, input logic [31:0] b);
        exp_t x;
        x.rdata = r; x.adel = l; x.ades = s; x.bad = b;
        sbq.push_back(x);
    endtask

    task automatic test_reset;
        rst = 1'b1;
        idle();
        step();
        step();
        vectors++;
        if ({done_o, adel_o, ades_o, stall_o, ram_we_o} !== 5'b0 ||
            rdata_o !== 32'h0 || bad_addr_o !== 32'h0 ||
            ram_addr_o !== 32'h0 || ram_data_o !== 32'h0) begin
            errors++;
            $display("FAIL reset: done=%b rdata=%h bad=%h we=%b addr=%h data=%h, required all 0",
                     done_o, rdata_o, bad_addr_o, ram_we_o, ram_addr_o, ram_data_o);
        end
        rst = 1'b0;
        step();
    endtask

    task automatic test_word_store_load;
        int w0;
        mem[4] = 32'h0;
        w0 = wr_cnt;
        drive(1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF);
        vectors++;
        if (ram_we_o !== 1'b1 || ram_data_o !== 32'hDEADBEEF ||
            ram_addr_o !== 32'h10 || stall_o !== 1'b0) begin
            errors++;
            $display("FAIL sw_accept: we=%b addr=%h data=%h stall=%b, required 1/10/deadbeef/0",
                     ram_we_o, ram_addr_o, ram_data_o, stall_o);
        end
        push(32'h0, 1'b0, 1'b0, 32'h0);
        step();
        vectors++;
        if (done_o !== 1'b1 || sbq.size() == 0) begin
            errors++;
            $display("FAIL sw_done: done=%b, required 1", done_o);
        end else begin
            e = sbq.pop_front();
            if ({rdata_o, adel_o, ades_o} !== {e.rdata, e.adel, e.ades}) begin
                errors++;
                $display("FAIL sw_done: rdata=%h adel=%b ades=%b, required %h/%b/%b",
                         rdata_o, adel_o, ades_o, e.rdata, e.adel, e.ades);
            end
        end
        drive(1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
        vectors++;
        if (ram_we_o !== 1'b0 || (wr_cnt - w0) != 1) begin
            errors++;
            $display("FAIL sw_one_write: we=%b writes=%0d, required 0 and 1",
                     ram_we_o, wr_cnt - w0);
        end
        push(32'hDEADBEEF, 1'b0, 1'b0, 32'h0);
        step();
        idle();
        vectors++;
        if (done_o !== 1'b1 || sbq.size() == 0) begin
            errors++;
            $display("FAIL lw_done: done=%b, required 1", done_o);
        end else begin
            e = sbq.pop_front();
            if (rdata_o !== e.rdata) begin
                errors++;
                $display("FAIL lw_data: rdata=%h, required %h", rdata_o, e.rdata);
            end
        end
        step();
        vectors++;
        if (done_o !== 1'b0 || rdata_o !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL lw_pulse: done=%b rdata=%h, required 0/deadbeef",
                     done_o, rdata_o);
        end
    endtask

    task automatic test_sub_store;
        int w0;
        mem[4] = 32'h11223344;
        mem[8] = 32'h55667788;
        w0 = wr_cnt;
        drive(1'b1, 2'b00, 1'b0, 32'h12, 32'h000000AB);
        vectors++;
        if (stall_o !== 1'b1 || ram_we_o !== 1'b0) begin
            errors++;
            $display("FAIL sb_accept: stall=%b we=%b, required 1/0", stall_o, ram_we_o);
        end
        push(32'h0, 1'b0, 1'b0, 32'h0);
        step();
        drive(1'b1, 2'b10, 1'b0, 32'h20, 32'h99999999);
        vectors++;
        if (stall_o !== 1'b1 || ram_we_o !== 1'b1 || ram_addr_o !== 32'h10 ||
            ram_data_o !== 32'h1122AB44 || done_o !== 1'b0) begin
            errors++;
            $display("FAIL sb_merge: stall=%b we=%b addr=%h data=%h done=%b, required 1/1/10/1122ab44/0",
                     stall_o, ram_we_o, ram_addr_o, ram_data_o, done_o);
        end
        req_i = 1'b0;
        step();
        for (int i = 0; i < 4 && done_o !== 1'b1; i++) step();
        idle();
        vectors++;
        if (done_o !== 1'b1 || sbq.size() == 0) begin
            errors++;
            $display("FAIL sb_done: done=%b, required 1 within bound", done_o);
        end else begin
            e = sbq.pop_front();
            if (rdata_o !== e.rdata || mem[4] !== 32'h1122AB44 ||
                mem[8] !== 32'h55667788 || (wr_cnt - w0) != 1) begin
                errors++;
                $display("FAIL sb_result: rdata=%h mem4=%h mem8=%h writes=%0d, required %h/1122ab44/55667788/1",
                         rdata_o, mem[4], mem[8], wr_cnt - w0, e.rdata);
            end
        end
        step();
    endtask

    task automatic test_extend;
        logic [31:0] ta[4] = '{32'h0, 32'h1, 32'h2, 32'h0};
        logic [1:0]  ts[4] = '{2'b00, 2'b00, 2'b01, 2'b01};
        logic        tx[4] = '{1'b1, 1'b0, 1'b1, 1'b0};
        logic [31:0] te[4] = '{32'hFFFFFF80, 32'h000000FF,
                               32'h00007F01, 32'h000080FF};
        mem[0] = 32'h80FF7F01;
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, ts[i], tx[i], ta[i], 32'h0);
            push(te[i], 1'b0, 1'b0, 32'h0);
            step();
            vectors++;
            if (done_o !== 1'b1 || sbq.size() == 0) begin
                errors++;
                $display("FAIL ext_%0d: done=%b, required 1", i, done_o);
            end else begin
                e = sbq.pop_front();
                if (rdata_o !== e.rdata) begin
                    errors++;
                    $display("FAIL ext_%0d: rdata=%h, required %h", i, rdata_o, e.rdata);
                end
            end
        end
        idle();
        step();
        vectors++;
        if (done_o !== 1'b0 || rdata_o !== 32'h000080FF) begin
            errors++;
            $display("FAIL ext_hold: done=%b rdata=%h, required 0/000080ff",
                     done_o, rdata_o);
        end
    endtask

    task automatic test_misaligned;
        int w0;
        w0 = wr_cnt;
        drive(1'b0, 2'b10, 1'b0, 32'h6, 32'h0);
        push(32'h0, 1'b1, 1'b0, 32'h6);
        vectors++;
        if (ram_we_o !== 1'b0 || stall_o !== 1'b0) begin
            errors++;
            $display("FAIL lw_mis_accept: we=%b stall=%b, required 0/0", ram_we_o, stall_o);
        end
        step();
        drive(1'b1, 2'b01, 1'b0, 32'h3, 32'h5555);
        vectors++;
        if (done_o !== 1'b1 || sbq.size() == 0) begin
            errors++;
            $display("FAIL lw_mis_done: done=%b, required 1", done_o);
        end else begin
            e = sbq.pop_front();
            if ({rdata_o, adel_o, ades_o, bad_addr_o} !== e) begin
                errors++;
                $display("FAIL lw_mis: rdata=%h adel=%b ades=%b bad=%h, required %h/%b/%b/%h",
                         rdata_o, adel_o, ades_o, bad_addr_o, e.rdata, e.adel, e.ades, e.bad);
            end
        end
        push(32'h0, 1'b0, 1'b1, 32'h3);
        vectors++;
        if (ram_we_o !== 1'b0 || stall_o !== 1'b0) begin
            errors++;
            $display("FAIL sh_mis_accept: we=%b stall=%b, required 0/0", ram_we_o, stall_o);
        end
        step();
        idle();
        vectors++;
        if (done_o !== 1'b1 || sbq.size() == 0) begin
            errors++;
            $display("FAIL sh_mis_done: done=%b, required 1", done_o);
        end else begin
            e = sbq.pop_front();
            if ({rdata_o, adel_o, ades_o, bad_addr_o} !== e) begin
                errors++;
                $display("FAIL sh_mis: rdata=%h adel=%b ades=%b bad=%h, required %h/%b/%b/%h",
                         rdata_o, adel_o, ades_o, bad_addr_o, e.rdata, e.adel, e.ades, e.bad);
            end
        end
        step();
        vectors++;
        if (adel_o !== 1'b0 || ades_o !== 1'b0 || ram_we_o !== 1'b0 ||
            wr_cnt != w0) begin
            errors++;
            $display("FAIL mis_pulse: adel=%b ades=%b we=%b writes=%0d, required 0/0/0/0",
                     adel_o, ades_o, ram_we_o, wr_cnt - w0);
        end
    endtask

    task automatic test_reset_in_merge;
        int w0;
        mem[2] = 32'hCAFEF00D;
        w0 = wr_cnt;
        drive(1'b1, 2'b01, 1'b0, 32'h8, 32'h1234);
        step();
        idle();
        rst = 1'b1;
        #1;
        vectors++;
        if (ram_we_o !== 1'b0 || stall_o !== 1'b0) begin
            errors++;
            $display("FAIL rst_merge_we: we=%b stall=%b, required 0/0", ram_we_o, stall_o);
        end
        step();
        rst = 1'b0;
        #1;
        vectors++;
        if (wr_cnt != w0 || mem[2] !== 32'hCAFEF00D ||
            {done_o, adel_o, ades_o, stall_o, ram_we_o} !== 5'b0 ||
            rdata_o !== 32'h0 || bad_addr_o !== 32'h0 ||
            ram_addr_o !== 32'h0 || ram_data_o !== 32'h0) begin
            errors++;
            $display("FAIL rst_merge: writes=%0d mem2=%h done=%b rdata=%h bad=%h we=%b, required 0/cafef00d/0/0/0/0",
                     wr_cnt - w0, mem[2], done_o, rdata_o, bad_addr_o, ram_we_o);
        end
        step();
        drive(1'b0, 2'b10, 1'b0, 32'h8, 32'h0);
        push(32'hCAFEF00D, 1'b0, 1'b0, 32'h0);
        step();
        idle();
        vectors++;
        if (done_o !== 1'b1 || sbq.size() == 0) begin
            errors++;
            $display("FAIL rst_lw_done: done=%b, required 1", done_o);
        end else begin
            e = sbq.pop_front();
            if (rdata_o !== e.rdata) begin
                errors++;
                $display("FAIL rst_lw: rdata=%h, required %h", rdata_o, e.rdata);
            end
        end
        step();
    endtask

    initial begin
        for (int i = 0; i < 16; i++) mem[i] = 32'h0;
        test_reset();
        test_word_store_load();
        test_sub_store();
        test_extend();
        test_misaligned();
        test_reset_in_merge();
        vectors++;
        if (sbq.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_left: %0d entries, required 0", sbq.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/data_mem_ctrl.md
# data_mem_ctrl

Memory-access initiator between the MEM pipeline stage and the word-only, single-port data RAM. The RAM reads combinationally, writes whole words on the clock edge, and reads as zero while its write enable is high. This block adds byte and halfword loads (sign- or zero-extended) and sub-word stores, which it implements as a two-cycle read-modify-write. It detects misaligned accesses and reports them as AdEL/AdES exception requests instead of touching the RAM. Byte order is big-endian: byte offset 0 is bits [31:24].

## Interface
- No parameters. Data width 32, address width 32.
- clk  in  1  system clock, all state updates on rising edge
- rst  in  1  reset, asynchronous, active-high
- req_i  in  1  access request from MEM stage, sampled only in IDLE
- we_i  in  1  1 = store, 0 = load
- size_i  in  2  00 byte, 01 halfword, 10 word, 11 reserved (treated as word)
- sext_i  in  1  loads only: 1 sign-extend, 0 zero-extend
- addr_i  in  32  byte address
- wdata_i  in  32  store data, right-justified for sub-word stores
- stall_o  out  1  pipeline hold request (combinational)
- done_o  out  1  one-cycle pulse when an access (or fault) completes
- rdata_o  out  32  extended load result, valid while done_o=1
- adel_o  out  1  load address-error pulse, coincident with done_o
- ades_o  out  1  store address-error pulse, coincident with done_o
- bad_addr_o  out  32  faulting address, valid with adel_o/ades_o
- ram_we_o  out  1  RAM write enable
- ram_addr_o  out  32  RAM address, always {addr[31:2],2'b00}
- ram_data_o  out  32  RAM write data
- ram_data_i  in  32  RAM read data

## Operation
- **States:** IDLE and MERGE_WR. Reset puts the block in IDLE and clears done_o, rdata_o, adel_o, ades_o, bad_addr_o and the merge register to 0.
- **Idle RAM outputs:** in IDLE with req_i=0, ram_we_o=0, ram_addr_o=0 and ram_data_o=0.
- **Alignment check:**
  - A halfword with addr_i[0]=1 is misaligned.
  - A word (or reserved size) with addr_i[1:0]≠00 is misaligned.
  - A byte access is always aligned.
  - On a misaligned request, ram_we_o=0 and the RAM is not accessed. On the next edge done_o=1, adel_o (load) or ades_o (store) =1, bad_addr_o=addr_i and rdata_o=0.
- **Load:**
  - The accept cycle drives ram_we_o=0 and ram_addr_o.
  - The block selects the lane using off=addr_i[1:0]. Byte lane = ram_data_i[31-8*off -: 8]. Halfword lane = [31:16] when off=00, [15:0] when off=10.
  - The lane is extended per sext_i and registered into rdata_o. done_o=1 on the next cycle.
  - stall_o=0; the block stays in IDLE.
- **Word store:** the accept cycle drives ram_we_o=1 and ram_data_o=wdata_i. done_o=1 next cycle, stall_o=0, block stays in IDLE.
- **Sub-word store:**
  - Accept cycle: drive ram_we_o=0 and read the word. Register the merged word (old word with the addressed lane replaced by wdata_i[7:0] or [15:0]). Latch the address. Assert stall_o. Go to MERGE_WR.
  - MERGE_WR: drive ram_we_o=1, the latched address and ram_data_o=merged word. stall_o=1, req_i is ignored. Return to IDLE; done_o=1 in the following cycle.
- **stall_o equation:** stall_o = (IDLE & req_i & we_i & aligned & size_i∈{00,01}) | MERGE_WR.
- **Extension widths:** 8→32 and 16→32 only. Zero-extend fills the upper bits with 0; sign-extend replicates bit 7 or bit 15.

## Timing
- Load latency: 1 cycle (request in cycle N → done_o and rdata_o in N+1).
- Word store latency: 1 cycle; the RAM is written at the end of cycle N.
- Sub-word store latency: 2 cycles. The RAM is written at the end of cycle N+1 and done_o fires in N+2. A new request can be accepted in N+2.
- Fault latency: 1 cycle, with no RAM write.
- done_o, adel_o and ades_o are single-cycle pulses. Back-to-back loads or word stores produce done_o on consecutive cycles.
- Reset asserted in MERGE_WR aborts the access: no RAM write occurs after reset, ram_we_o goes 0 immediately, and the block is in IDLE once rst drops.
- rdata_o holds its value until the next load or fault completes. A store completion clears rdata_o to 0.

## Test plan
- Word store 0xDEADBEEF to 0x10, then lw 0x10 → ram_we_o=1 for exactly one cycle; load done_o next cycle with rdata_o=0xDEADBEEF.
- sb 0xAB to 0x12 over word 0x11223344 → stall_o=1 for 2 cycles; RAM write of 0x1122AB44 in the second cycle; done_o one cycle later.
- Word 0x80FF7F01: lb at 0x0 → 0xFFFFFF80; lbu at 0x1 → 0x000000FF; lh at 0x2 → 0x00007F01; lhu at 0x0 → 0x000080FF.
- lw at 0x6 → adel_o=1, bad_addr_o=0x6, no RAM access; sh at 0x3 → ades_o=1, ram_we_o stays 0 throughout.
- Assert rst during MERGE_WR of an sh → no RAM write occurs; after release all outputs are 0 and a following lw returns the unmodified word.
- req_i held high during MERGE_WR with different addr_i → ignored; the write uses the latched address and merged data.
